// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster timing constants and scan FSM encoding
package vga_timing_pkg;

  // Every position counter and coordinate is this wide.
  localparam int CNT_W = 10;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Sync pulses sit right after the front porch.
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - mod-N position counter with terminal count and window decode
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int N      = H_TOTAL,
  parameter int WIN_LO = H_SYNC_START,
  parameter int WIN_HI = H_SYNC_END,
  parameter int VIS    = H_DISPLAY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             win_nxt,
  output logic             vis_nxt
);

  logic [CNT_W-1:0] count_nxt;

  // Terminal count is the last position of the axis, independent of inc.
  assign tc = (count == CNT_W'(N - 1));

  // Next position: clear wins, otherwise wrap or step on inc, else hold.
  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (inc) begin
      count_nxt = tc ? '0 : count + CNT_W'(1);
    end
  end

  // Decodes of the next position, so registered users line up with count.
  assign win_nxt = (count_nxt >= CNT_W'(WIN_LO)) && (count_nxt <= CNT_W'(WIN_HI));
  assign vis_nxt = (count_nxt < CNT_W'(VIS));

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_ctrl.sv
// rtl/vga_sync_ctrl.sv - frame-aligned VGA raster scan controller
module vga_sync_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int   H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BACK    = vga_timing_pkg::H_BACK,
  parameter int   V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int   V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BACK    = vga_timing_pkg::V_BACK,
  parameter logic SYNC_ACT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_tick,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_end,
  output logic             frame_end,
  output logic             busy
);

  localparam int HTOT    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VTOT    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_LO   = H_DISPLAY + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC - 1;
  localparam int VS_LO   = V_DISPLAY + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC - 1;

  state_t state, state_nxt;
  logic   active;
  logic   h_inc, h_tc, h_win, h_vis;
  logic   v_tc, v_win, v_vis;
  logic   cnt_clr;

  assign h_inc   = pix_tick & active;
  assign cnt_clr = (state_nxt == ST_IDLE);

  vga_axis_counter #(
    .N(HTOT), .WIN_LO(HS_LO), .WIN_HI(HS_HI), .VIS(H_DISPLAY)
  ) u_hcnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(h_inc),
    .count(pixel_x), .tc(h_tc), .win_nxt(h_win), .vis_nxt(h_vis)
  );

  vga_axis_counter #(
    .N(VTOT), .WIN_LO(VS_LO), .WIN_HI(VS_HI), .VIS(V_DISPLAY)
  ) u_vcnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .inc(line_end),
    .count(pixel_y), .tc(v_tc), .win_nxt(v_win), .vis_nxt(v_vis)
  );

  // Scan state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Start/stop transitions; leaving the scan only happens at the end of a frame.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_RUN;
      ST_RUN:   if (!en) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (en) begin
          state_nxt = ST_RUN;
        end else if (frame_end) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State-derived strobes and status.
  always_comb begin
    active    = (state != ST_IDLE);
    busy      = active;
    line_end  = pix_tick & h_tc & active;
    frame_end = line_end & v_tc;
  end

  // Sync and visible-area flags registered from the next position for zero lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync    <= ~SYNC_ACT;
      vsync    <= ~SYNC_ACT;
      video_on <= 1'b0;
    end else if (state_nxt == ST_IDLE) begin
      hsync    <= ~SYNC_ACT;
      vsync    <= ~SYNC_ACT;
      video_on <= 1'b0;
    end else begin
      hsync    <= h_win ? SYNC_ACT : ~SYNC_ACT;
      vsync    <= v_win ? SYNC_ACT : ~SYNC_ACT;
      video_on <= h_vis & v_vis;
    end
  end

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// tb/tb_vga_sync_ctrl.sv - self-checking bench for vga_sync_ctrl (reduced and full timing)
module tb_vga_sync_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_tick = 1'b0;
  logic en_s = 1'b0;
  logic en_f = 1'b0;

  // Index 0: reduced-timing instance, index 1: full 640x480 instance.
  logic       hs [2];
  logic       vs [2];
  logic       vo [2];
  logic       le [2];
  logic       fe [2];
  logic       bz [2];
  logic [9:0] px [2];
  logic [9:0] py [2];

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit tick_on = 1'b0;
  int div = 0;

  always #5 clk = ~clk;

  vga_sync_ctrl #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(3), .SYNC_ACT(1'b0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .en(en_s),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]),
    .pixel_x(px[0]), .pixel_y(py[0]),
    .line_end(le[0]), .frame_end(fe[0]), .busy(bz[0])
  );

  vga_sync_ctrl dut_f (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .en(en_f),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]),
    .pixel_x(px[1]), .pixel_y(py[1]),
    .line_end(le[1]), .frame_end(fe[1]), .busy(bz[1])
  );

  // Timing of each instance.
  function automatic int hd(int i); return i ? 640 : 16; endfunction
  function automatic int hf(int i); return i ? 16  : 4;  endfunction
  function automatic int hw(int i); return i ? 96  : 6;  endfunction
  function automatic int ht(int i); return i ? 800 : 30; endfunction
  function automatic int vd(int i); return i ? 480 : 12; endfunction
  function automatic int vf(int i); return i ? 10  : 3;  endfunction
  function automatic int vw(int i); return i ? 2   : 2;  endfunction
  function automatic int vt(int i); return i ? 525 : 20; endfunction

  // Model: scan mode (0 idle, 1 run, 2 drain) and linear pixel index in the frame.
  int mmode [2];
  int mpos  [2];

  function automatic int exp_x(int i); return mpos[i] % ht(i); endfunction
  function automatic int exp_y(int i); return mpos[i] / ht(i); endfunction
  function automatic int exp_busy(int i); return (mmode[i] != 0) ? 1 : 0; endfunction
  function automatic int exp_hs(int i);
    int x = exp_x(i);
    return (mmode[i] != 0 && x >= hd(i) + hf(i) && x < hd(i) + hf(i) + hw(i)) ? 0 : 1;
  endfunction
  function automatic int exp_vs(int i);
    int y = exp_y(i);
    return (mmode[i] != 0 && y >= vd(i) + vf(i) && y < vd(i) + vf(i) + vw(i)) ? 0 : 1;
  endfunction
  function automatic int exp_vo(int i);
    return (mmode[i] != 0 && exp_x(i) < hd(i) && exp_y(i) < vd(i)) ? 1 : 0;
  endfunction
  function automatic int exp_le(int i);
    return (pix_tick && mmode[i] != 0 && exp_x(i) == ht(i) - 1) ? 1 : 0;
  endfunction
  function automatic int exp_fe(int i);
    return (exp_le(i) == 1 && exp_y(i) == vt(i) - 1) ? 1 : 0;
  endfunction
  function automatic int next_pos(int i);
    return (mmode[i] != 0 && pix_tick) ? (mpos[i] + 1) % (ht(i) * vt(i)) : mpos[i];
  endfunction
  function automatic int next_mode(int i, logic e);
    case (mmode[i])
      0:       return e ? 1 : 0;
      1:       return e ? 1 : 2;
      default: return e ? 1 : ((pix_tick && mpos[i] == ht(i) * vt(i) - 1) ? 0 : 2);
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model advance on each clock edge; async reset returns it to frame start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mmode[i] <= 0;
        mpos[i]  <= 0;
      end
    end else begin
      mmode[0] <= next_mode(0, en_s);
      mmode[1] <= next_mode(1, en_f);
      mpos[0]  <= next_pos(0);
      mpos[1]  <= next_pos(1);
    end
  end

  // Pixel strobe: one clk in four, changed just after the active edge.
  always @(posedge clk) begin
    #1;
    div <= div + 1;
    pix_tick = tick_on && (div % 4 == 3);
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      for (int i = 0; i < 2; i++) begin
        cmp($sformatf("x[%0d]", i), int'(px[i]), exp_x(i));
        cmp($sformatf("y[%0d]", i), int'(py[i]), exp_y(i));
        cmp($sformatf("hsync[%0d]", i), int'(hs[i]), exp_hs(i));
        cmp($sformatf("vsync[%0d]", i), int'(vs[i]), exp_vs(i));
        cmp($sformatf("video_on[%0d]", i), int'(vo[i]), exp_vo(i));
        cmp($sformatf("line_end[%0d]", i), int'(le[i]), exp_le(i));
        cmp($sformatf("frame_end[%0d]", i), int'(fe[i]), exp_fe(i));
        cmp($sformatf("busy[%0d]", i), int'(bz[i]), exp_busy(i));
      end
    end
  end

  // Frame statistics (reduced instance) and line statistics (full instance).
  int fe_seen = 0, f_clks = 0, f_vid = 0, f_le = 0, f_fe = 0, f_vlow = 0;
  int lf_seen = 0, l_clks = 0, l_hlow = 0, l_first_x = -1;
  always @(negedge clk) begin
    if (chk_on) begin
      if (fe_seen == 1) begin
        f_clks++;
        if (pix_tick && vo[0]) f_vid++;
        if (pix_tick && !vs[0]) f_vlow++;
        if (le[0]) f_le++;
        if (fe[0]) f_fe++;
      end
      if (fe[0]) fe_seen++;
      if (lf_seen == 1) begin
        l_clks++;
        if (pix_tick && !hs[1]) l_hlow++;
        if (!hs[1] && l_first_x < 0) l_first_x = int'(px[1]);
      end
      if (le[1]) lf_seen++;
    end
  end

  task automatic wait_pos(input int y, input int x);
    int k;
    for (k = 0; k < 5000; k++) begin
      @(posedge clk); #1;
      if (exp_y(0) == y && (x < 0 || exp_x(0) == x)) break;
    end
    cmp($sformatf("wait_pos_%0d_%0d", y, x), (k < 5000) ? 1 : 0, 1);
  endtask

  initial begin
    int xm, ym, k;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_on = 1'b1;
    tick_on = 1'b1;

    // Disabled scan ignores the strobe entirely.
    repeat (10000) @(posedge clk);
    @(negedge clk); #1;
    cmp("idle_hsync_s", int'(hs[0]), 1);
    cmp("idle_vsync_s", int'(vs[0]), 1);
    cmp("idle_hsync_f", int'(hs[1]), 1);
    cmp("idle_vsync_f", int'(vs[1]), 1);
    cmp("idle_busy", int'(bz[0]), 0);
    cmp("idle_video", int'(vo[0]), 0);
    cmp("idle_x", int'(px[0]), 0);
    cmp("idle_y", int'(py[0]), 0);

    // Start both scans and collect one full frame / one full line.
    @(posedge clk); #1;
    en_s = 1'b1;
    en_f = 1'b1;
    for (k = 0; k < 12000 && !(fe_seen >= 2 && lf_seen >= 2); k++) @(posedge clk);
    cmp("measure_timeout", (fe_seen >= 2 && lf_seen >= 2) ? 1 : 0, 1);
    cmp("frame_clks", f_clks, 2400);
    cmp("frame_video_ticks", f_vid, 192);
    cmp("frame_vsync_low_ticks", f_vlow, 60);
    cmp("frame_line_ends", f_le, 20);
    cmp("frame_frame_ends", f_fe, 1);
    cmp("line_clks", l_clks, 3200);
    cmp("line_hsync_low_ticks", l_hlow, 96);
    cmp("line_hsync_first_x", l_first_x, 656);

    // Drop en mid-frame, re-raise in drain, then drop again and drain to idle.
    wait_pos(3, -1);
    en_s = 1'b0;
    wait_pos(9, -1);
    en_s = 1'b1;
    @(posedge clk); #1;
    cmp("resume_busy", int'(bz[0]), 1);
    cmp("resume_y", int'(py[0]), 9);
    wait_pos(11, -1);
    en_s = 1'b0;
    for (k = 0; k < 3000 && mmode[0] != 0; k++) begin
      @(posedge clk); #1;
    end
    cmp("drain_timeout", (mmode[0] == 0) ? 1 : 0, 1);
    @(negedge clk); #1;
    cmp("drained_busy", int'(bz[0]), 0);
    cmp("drained_x", int'(px[0]), 0);
    cmp("drained_y", int'(py[0]), 0);
    cmp("drained_video", int'(vo[0]), 0);

    // Strobe held low mid-line freezes position.
    @(posedge clk); #1;
    en_s = 1'b1;
    wait_pos(2, 10);
    @(negedge clk);
    tick_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    xm = exp_x(0);
    ym = exp_y(0);
    repeat (50) @(posedge clk);
    #1;
    cmp("freeze_x", int'(px[0]), xm);
    cmp("freeze_y", int'(py[0]), ym);
    @(negedge clk);
    tick_on = 1'b1;

    // Async reset inside both sync pulses.
    wait_pos(16, 23);
    @(negedge clk); #1;
    cmp("pre_rst_hsync", int'(hs[0]), 0);
    cmp("pre_rst_vsync", int'(vs[0]), 0);
    #1 rst = 1'b1;
    #1;
    cmp("rst_hsync", int'(hs[0]), 1);
    cmp("rst_vsync", int'(vs[0]), 1);
    cmp("rst_x", int'(px[0]), 0);
    cmp("rst_y", int'(py[0]), 0);
    cmp("rst_busy", int'(bz[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cmp("restart_busy", int'(bz[0]), 1);
    cmp("restart_x", int'(px[0]), 0);
    cmp("restart_y", int'(py[0]), 0);
    cmp("restart_video", int'(vo[0]), 1);
    repeat (200) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
